mc_ctrl: RTL
============

# mc_ctrl

Multi-cycle control unit driving the single-cycle-style MIPS datapath as a multi-cycle machine. Sits directly upstream of the datapath: consumes `opcode`, `funct`, `zero`, `positive` and `overflow`, and produces every datapath control strobe plus PC/IR write enables. One instruction completes in 3–5 cycles. Only one register-file, memory and PC write is issued per instruction.

## Interface
- No parameters.
- `clk  in  1` — rising-edge clock.
- `rst  in  1` — synchronous, active-low reset.
- `opcode  in  6` — IR[31:26]; stable from DECODE onward.
- `funct  in  6` — IR[5:0].
- `zero, positive, overflow  in  1 each` — ALU flags.
- `pc_write  out  1` — PC update enable.
- `ir_write  out  1` — IR load enable.
- `alu_ctl  out  2` — ADD=00, SUB=01, OR=10.
- `ext_op  out  1` — 0 zero-extend, 1 sign-extend.
- `alu_src  out  1` — 0 register, 1 extended immediate.
- `reg_dst  out  2` — RD=00, RT=01, OVERFLOW($30)=10, NPC($31)=11.
- `reg_src  out  3` — ALU=000, MEM=001, ZERO=010, ONE=011, PC=100.
- `reg_write, mem_write, npc_sel, j_ctl, jr_ctl, bltzal  out  1 each` — datapath strobes.
- `illegal  out  1` — one-cycle pulse on an undecodable instruction.
- `cycle_cnt, instret_cnt  out  32 each` — present only with `MC_CTRL_PERF_EN`.

## Operation
- **States** (3-bit): FETCH=0, DECODE=1, EXEC=2, MEMRD=3, MEMWR=4, WB=5, BRANCH=6, JUMP=7.
- **FETCH:** `ir_write=1`; next state DECODE.
- **DECODE:** classify the instruction.
  - R-type (opcode 000000): addu (100001), subu (100011), jr (001000).
  - I-type: ori 001101, addi 001000, lw 100011, sw 101011, beq 000100.
  - J-type: j 000010, jal 000011.
  - REGIMM 000001 is bltzal.
- **Transitions out of DECODE:**
  - addu/subu/ori/addi/lw/sw → EXEC.
  - beq/bltzal → BRANCH.
  - j/jal/jr → JUMP.
  - Anything else → FETCH, with `illegal=1` and `pc_write=1` (sequential).
- **EXEC:** ALU operand setup.
  - addu: ADD/REG. subu: SUB/REG. ori: OR/EXT with `ext_op=0`.
  - addi/lw/sw: ADD/EXT with `ext_op=1`.
  - Next state: lw → MEMRD; sw → MEMWR; others → WB.
- **MEMRD:** holds the EXEC ALU controls; next state WB.
- **MEMWR:** holds the EXEC ALU controls; `mem_write=1`, `pc_write=1`; next state FETCH.
- **WB:** holds the ALU controls; `reg_write=1`, `pc_write=1`; next state FETCH.
  - addu/subu: dst RD, src ALU.
  - ori: dst RT, src ALU.
  - lw: dst RT, src MEM.
  - addi with `overflow=0`: dst RT, src ALU.
  - addi with `overflow=1`: dst OVERFLOW, src ONE. Rt is not written.
- **BRANCH:** `pc_write=1`; next state FETCH.
  - beq: SUB/REG, `npc_sel=1`; the datapath qualifies the branch with `zero`.
  - bltzal: `bltzal=1`, `reg_write=1`, dst NPC, src PC. The link is written whether or not `positive` takes the branch.
- **JUMP:** `pc_write=1`; next state FETCH.
  - j: `j_ctl=1`.
  - jal: `j_ctl=1`, `reg_write=1`, dst NPC, src PC.
  - jr: `jr_ctl=1`.
- Every output not listed for the current state/instruction is 0.

## Timing
- Outputs are combinational from the registered state and the stable IR fields. There is no output register.
- Cycles per instruction:
  - addu/subu/ori/addi/sw: 4.
  - lw: 5.
  - beq/bltzal/j/jal/jr: 3.
  - illegal: 2.
- `pc_write` is asserted exactly once per instruction, in its final state.
- **Reset:** while `rst=0`, all outputs are forced to 0 and the state loads FETCH at the edge. A reset mid-instruction abandons it with no partial write. The first cycle after release is FETCH.
- Flags are sampled only in WB (addi) and in BRANCH, via the datapath. No register writes occur before then, so the flags are stable.

## Configuration
- **`MC_CTRL_PERF_EN` defined:** `cycle_cnt` and `instret_cnt` exist.
  - Both reset to 0.
  - `cycle_cnt` increments every cycle with `rst=1`.
  - `instret_cnt` increments on every `pc_write`, including illegal.
  - Both wrap modulo 2^32.
- **Undefined:** both ports and their registers are absent. Control behaviour is identical.

## Structure
- State encodings, opcode/funct values and all control field encodings (ALU_CTL, REG_DST, REG_SRC, ALU_SRC, EXT) belong in the shared `defines.v`.
- Sub-module `mc_ctrl_decode` is combinational: opcode/funct → one-hot instruction class plus `illegal`.

## Test plan
- Reset held 3 cycles, then `addu` (opcode 0, funct 100001) → 4 cycles FETCH/DECODE/EXEC/WB. In WB: `reg_write=1`, `reg_dst=00`, `reg_src=000`, `pc_write=1`. All outputs are 0 during reset.
- `lw` (100011) → `ir_write` in cycle 1; EXEC `alu_src=1`, `ext_op=1`; WB `reg_src=001`, `reg_dst=01` in cycle 5; `mem_write` never asserted.
- `addi` with `overflow=1` in WB → `reg_dst=10`, `reg_src=011`, `reg_write=1`. Repeated with `overflow=0` → `reg_dst=01`, `reg_src=000`.
- `jal` (000011) → in cycle 3: `j_ctl=1`, `reg_write=1`, `reg_dst=11`, `reg_src=100`, `pc_write=1`. `bltzal` (000001) with `positive=0` → link written, `bltzal=1`.
- Opcode 111111 → `illegal` pulses in DECODE with `pc_write=1`; FETCH follows. `rst=0` during an sw EXEC → no `mem_write`; FETCH after release.
- With `MC_CTRL_PERF_EN`: 10 reset-free cycles of j instructions → `cycle_cnt=10`, `instret_cnt=3`. Preloaded 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// opcode/funct values, datapath control field encodings and the
// instruction-class / control-bundle types used by mc_ctrl and its decoder.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEMRD  = 3'd3,
    ST_MEMWR  = 3'd4,
    ST_WB     = 3'd5,
    ST_BRANCH = 3'd6,
    ST_JUMP   = 3'd7
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // Datapath control field encodings
  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_OR      = 2'b10;
  localparam logic       EXT_ZERO    = 1'b0;
  localparam logic       EXT_SIGN    = 1'b1;
  localparam logic       ALU_SRC_REG = 1'b0;
  localparam logic       ALU_SRC_EXT = 1'b1;
  localparam logic [1:0] DST_RD      = 2'b00;
  localparam logic [1:0] DST_RT      = 2'b01;
  localparam logic [1:0] DST_OVF     = 2'b10;
  localparam logic [1:0] DST_NPC     = 2'b11;
  localparam logic [2:0] SRC_ALU     = 3'b000;
  localparam logic [2:0] SRC_MEM     = 3'b001;
  localparam logic [2:0] SRC_ZERO    = 3'b010;
  localparam logic [2:0] SRC_ONE     = 3'b011;
  localparam logic [2:0] SRC_PC      = 3'b100;

  // One-hot instruction class produced by the decoder
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic addi;
    logic lw;
    logic sw;
    logic beq;
    logic bltzal;
    logic j;
    logic jal;
  } insn_t;

  localparam insn_t INSN_NONE = 11'b0;

  // Full set of control strobes driven towards the datapath
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic [1:0] alu_ctl;
    logic       ext_op;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic [2:0] reg_src;
    logic       reg_write;
    logic       mem_write;
    logic       npc_sel;
    logic       j_ctl;
    logic       jr_ctl;
    logic       bltzal;
    logic       illegal;
  } ctl_t;

  localparam ctl_t CTL_NONE = 18'b0;

  function automatic logic is_exec_grp(input insn_t i);
    return i.addu | i.subu | i.ori | i.addi | i.lw | i.sw;
  endfunction

  function automatic logic is_branch_grp(input insn_t i);
    return i.beq | i.bltzal;
  endfunction

  function automatic logic is_jump_grp(input insn_t i);
    return i.j | i.jal | i.jr;
  endfunction

  // ALU operand setup chosen in EXEC and held through MEMRD/MEMWR/WB
  function automatic ctl_t exec_alu(input insn_t i);
    ctl_t c;
    c = CTL_NONE;
    if (i.subu) begin
      c.alu_ctl = ALU_SUB;
      c.alu_src = ALU_SRC_REG;
    end else if (i.ori) begin
      c.alu_ctl = ALU_OR;
      c.alu_src = ALU_SRC_EXT;
      c.ext_op  = EXT_ZERO;
    end else if (i.addi | i.lw | i.sw) begin
      c.alu_ctl = ALU_ADD;
      c.alu_src = ALU_SRC_EXT;
      c.ext_op  = EXT_SIGN;
    end else begin
      c.alu_ctl = ALU_ADD;
      c.alu_src = ALU_SRC_REG;
    end
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct to a one-hot class
// vector, with illegal raised when no supported instruction matches.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output insn_t      insn_o,
  output logic       illegal_o
);

  // Classify the instruction held in IR
  always_comb begin
    insn_o = INSN_NONE;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: insn_o.addu = 1'b1;
          FN_SUBU: insn_o.subu = 1'b1;
          FN_JR:   insn_o.jr   = 1'b1;
          default: insn_o      = INSN_NONE;
        endcase
      end
      OP_REGIMM: insn_o.bltzal = 1'b1;
      OP_J:      insn_o.j      = 1'b1;
      OP_JAL:    insn_o.jal    = 1'b1;
      OP_BEQ:    insn_o.beq    = 1'b1;
      OP_ADDI:   insn_o.addi   = 1'b1;
      OP_ORI:    insn_o.ori    = 1'b1;
      OP_LW:     insn_o.lw     = 1'b1;
      OP_SW:     insn_o.sw     = 1'b1;
      default:   insn_o        = INSN_NONE;
    endcase
    illegal_o = ~(|insn_o);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit for the MIPS datapath. Outputs are decoded
// combinationally from the state register and the stable IR fields and are
// forced to zero while rst is low.
// Optional feature: define MC_CTRL_PERF_EN to add cycle_cnt / instret_cnt.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        positive,
  input  logic        overflow,
  output logic        pc_write,
  output logic        ir_write,
  output logic [1:0]  alu_ctl,
  output logic        ext_op,
  output logic        alu_src,
  output logic [1:0]  reg_dst,
  output logic [2:0]  reg_src,
  output logic        reg_write,
  output logic        mem_write,
  output logic        npc_sel,
  output logic        j_ctl,
  output logic        jr_ctl,
  output logic        bltzal,
  output logic        illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_e state_q;
  state_e state_d;
  insn_t  insn_s;
  logic   dec_illegal_s;
  ctl_t   ctl_s;
  ctl_t   ctl_out_s;

  // zero/positive qualify branches inside the datapath, not here
  logic unused_flags_s;
  assign unused_flags_s = zero ^ positive;

  mc_ctrl_decode u_decode (
    .opcode_i  (opcode),
    .funct_i   (funct),
    .insn_o    (insn_s),
    .illegal_o (dec_illegal_s)
  );

  // Next-state selection
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_exec_grp(insn_s)) begin
          state_d = ST_EXEC;
        end else if (is_branch_grp(insn_s)) begin
          state_d = ST_BRANCH;
        end else if (is_jump_grp(insn_s)) begin
          state_d = ST_JUMP;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (insn_s.lw) begin
          state_d = ST_MEMRD;
        end else if (insn_s.sw) begin
          state_d = ST_MEMWR;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEMRD:  state_d = ST_WB;
      ST_MEMWR:  state_d = ST_FETCH;
      ST_WB:     state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Control strobes for the current state and instruction class
  always_comb begin
    ctl_s = CTL_NONE;
    case (state_q)
      ST_FETCH: ctl_s.ir_write = 1'b1;
      ST_DECODE: begin
        if (dec_illegal_s) begin
          ctl_s.illegal  = 1'b1;
          ctl_s.pc_write = 1'b1;
        end else begin
          ctl_s.illegal  = 1'b0;
        end
      end
      ST_EXEC, ST_MEMRD: ctl_s = exec_alu(insn_s);
      ST_MEMWR: begin
        ctl_s           = exec_alu(insn_s);
        ctl_s.mem_write = 1'b1;
        ctl_s.pc_write  = 1'b1;
      end
      ST_WB: begin
        ctl_s           = exec_alu(insn_s);
        ctl_s.reg_write = 1'b1;
        ctl_s.pc_write  = 1'b1;
        if (insn_s.addi && overflow) begin
          ctl_s.reg_dst = DST_OVF;
          ctl_s.reg_src = SRC_ONE;
        end else if (insn_s.lw) begin
          ctl_s.reg_dst = DST_RT;
          ctl_s.reg_src = SRC_MEM;
        end else if (insn_s.addu || insn_s.subu) begin
          ctl_s.reg_dst = DST_RD;
          ctl_s.reg_src = SRC_ALU;
        end else begin
          ctl_s.reg_dst = DST_RT;
          ctl_s.reg_src = SRC_ALU;
        end
      end
      ST_BRANCH: begin
        ctl_s.pc_write = 1'b1;
        if (insn_s.beq) begin
          ctl_s.alu_ctl = ALU_SUB;
          ctl_s.alu_src = ALU_SRC_REG;
          ctl_s.npc_sel = 1'b1;
        end else begin
          // bltzal links unconditionally; the datapath decides the branch
          ctl_s.bltzal    = 1'b1;
          ctl_s.reg_write = 1'b1;
          ctl_s.reg_dst   = DST_NPC;
          ctl_s.reg_src   = SRC_PC;
        end
      end
      ST_JUMP: begin
        ctl_s.pc_write = 1'b1;
        if (insn_s.jr) begin
          ctl_s.jr_ctl = 1'b1;
        end else if (insn_s.jal) begin
          ctl_s.j_ctl     = 1'b1;
          ctl_s.reg_write = 1'b1;
          ctl_s.reg_dst   = DST_NPC;
          ctl_s.reg_src   = SRC_PC;
        end else begin
          ctl_s.j_ctl = 1'b1;
        end
      end
      default: ctl_s = CTL_NONE;
    endcase
  end

  // All strobes are held low while reset is asserted
  assign ctl_out_s = rst ? ctl_s : CTL_NONE;

  assign pc_write  = ctl_out_s.pc_write;
  assign ir_write  = ctl_out_s.ir_write;
  assign alu_ctl   = ctl_out_s.alu_ctl;
  assign ext_op    = ctl_out_s.ext_op;
  assign alu_src   = ctl_out_s.alu_src;
  assign reg_dst   = ctl_out_s.reg_dst;
  assign reg_src   = ctl_out_s.reg_src;
  assign reg_write = ctl_out_s.reg_write;
  assign mem_write = ctl_out_s.mem_write;
  assign npc_sel   = ctl_out_s.npc_sel;
  assign j_ctl     = ctl_out_s.j_ctl;
  assign jr_ctl    = ctl_out_s.jr_ctl;
  assign bltzal    = ctl_out_s.bltzal;
  assign illegal   = ctl_out_s.illegal;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instret_cnt_q;

  // Free-running cycle counter and retired-instruction counter (wrap at 2^32)
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt_q   <= 32'd0;
      instret_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (ctl_out_s.pc_write) begin
        instret_cnt_q <= instret_cnt_q + 32'd1;
      end else begin
        instret_cnt_q <= instret_cnt_q;
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule
